char_glyph_fetch: RTL and testbench

- Parametrised single-clock successor to the text-mode character bitmap store.
- Holds font/glyph RAM with a byte-wide CPU port; a video-side request/valid handshake fetches one glyph scanline of up to MAX_COLS pixels.
- The scanline comes back as a single atomic word: a request-driven FSM replaces free-running ce_i timing.
- Sits between the text controller's character fetch pipeline and its pixel shifter.

---
 rtl/char_glyph_pkg.sv | 30 +++
 rtl/char_glyph_fetch_if.sv | 37 +++
 rtl/char_glyph_ram.sv | 27 ++
 rtl/char_glyph_fetch.sv | 195 +++++++++++++++++++
 tb/tb_char_glyph_fetch.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/char_glyph_pkg.sv
// Shared types and helpers for the glyph scanline fetch unit.
package char_glyph_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ADR,
    FETCH,
    DONE
  } state_t;

  localparam int DEF_MAX_COLS = 64;
  localparam int MAX_BYTES = DEF_MAX_COLS / 8;

  function automatic int max_bytes(int cols);
    return cols / 8;
  endfunction

  // Bytes per glyph row from width-1, clamped to the bitmap word.
  function automatic logic [3:0] bytes_per_row(
    logic [5:0] scanpix,
    int mb
  );
    logic [3:0] n;
    n = 4'(scanpix[5:3]) + 4'd1;
    if (int'(n) > mb) n = 4'(mb);
    return n;
  endfunction

endpackage

// File: rtl/char_glyph_fetch_if.sv
// CPU byte port and video fetch handshake of the glyph fetch unit.
interface char_glyph_fetch_if #(
  parameter int ADDR_W   = 16,
  parameter int MAX_COLS = 64,
  parameter int CODE_W   = 13,
  parameter int SCAN_W   = 6
);
  logic                cs_i;
  logic                we_i;
  logic [ADDR_W-1:0]   adr_i;
  logic [7:0]          dat_i;
  logic [7:0]          dat_o;
  logic                ack_o;
  logic                req_i;
  logic [ADDR_W-1:0]   font_base_i;
  logic [CODE_W-1:0]   char_code_i;
  logic [SCAN_W-1:0]   max_scanpix_i;
  logic [SCAN_W-1:0]   max_scanline_i;
  logic [SCAN_W-1:0]   scanline_i;
  logic                busy_o;
  logic                valid_o;
  logic [MAX_COLS-1:0] bmp_o;

  modport master (
    output cs_i, we_i, adr_i, dat_i,
    output req_i, font_base_i, char_code_i,
    output max_scanpix_i, max_scanline_i, scanline_i,
    input  dat_o, ack_o, busy_o, valid_o, bmp_o
  );

  modport slave (
    input  cs_i, we_i, adr_i, dat_i,
    input  req_i, font_base_i, char_code_i,
    input  max_scanpix_i, max_scanline_i, scanline_i,
    output dat_o, ack_o, busy_o, valid_o, bmp_o
  );
endinterface

// File: rtl/char_glyph_ram.sv
// Dual-port glyph byte RAM: port A CPU read/write, port B video read.
module char_glyph_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [7:0]        b_rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Video port samples before the write lands: read-first.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
    end
    if (b_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/char_glyph_fetch.sv
// Glyph RAM with CPU byte port and request-driven scanline fetch.
// Optional one-entry result cache: CHAR_GLYPH_FETCH_CACHE_EN.
module char_glyph_fetch
  import char_glyph_pkg::*;
#(
  parameter string FONT_FILE = "char_bitmaps_12x18.mem",
  parameter int    ADDR_W    = 16,
  parameter int    MAX_COLS  = 64,
  parameter int    CODE_W    = 13,
  parameter int    SCAN_W    = 6
) (
  input logic              clk_i,
  input logic              rst_ni,
  char_glyph_fetch_if.slave bus
);

  localparam int MB    = max_bytes(MAX_COLS);
  localparam int ROW_W = CODE_W + SCAN_W;
  localparam int PW    = ROW_W + 4;

  state_t              state;
  logic                busy;
  logic                valid;
  logic [MAX_COLS-1:0] bmp;
  logic [CODE_W-1:0]   code_q;
  logic [SCAN_W-1:0]   msl_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          n_q;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          cnt;
  logic [MAX_COLS-1:0] stage;
  logic [MAX_COLS-1:0] word;
  logic [ROW_W-1:0]    row_c;
  logic [PW-1:0]       prod;
  logic [ADDR_W-1:0]   addr_c;
  logic [ADDR_W-1:0]   b_addr;
  logic                b_en;
  logic [7:0]          b_q;
  logic [7:0]          a_q;
  logic                cpu_wr;
  logic                cpu_rd;
  logic                rd_p1;
  logic                ack;
  logic [7:0]          dat;

  assign cpu_wr = bus.cs_i & bus.we_i;
  assign cpu_rd = bus.cs_i & ~bus.we_i;

  assign row_c = ROW_W'(code_q) * (ROW_W'(msl_q) + ROW_W'(1))
               + ROW_W'(scan_q);
  assign prod   = PW'(row_q) * PW'(n_q);
  assign addr_c = (base_q & ~ADDR_W'(7)) + ADDR_W'(prod);
  assign b_addr = addr_q + ADDR_W'(cnt);
  assign b_en   = (state == FETCH) && (cnt < n_q);

  // Last byte comes straight from the RAM; bytes past n read as zero.
  always_comb begin
    word = stage;
    for (int j = 0; j < MB; j++) begin
      if (j + 1 == int'(n_q)) word[8*j +: 8] = b_q;
      else if (j >= int'(n_q)) word[8*j +: 8] = '0;
    end
  end

  char_glyph_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk_i),
    .a_en    (bus.cs_i),
    .a_we    (bus.we_i),
    .a_addr  (bus.adr_i),
    .a_wdata (bus.dat_i),
    .a_rdata (a_q),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_rdata (b_q)
  );

`ifdef CHAR_GLYPH_FETCH_CACHE_EN
  logic                c_valid;
  logic                c_stale;
  logic [ADDR_W-1:0]   c_addr;
  logic [3:0]          c_n;
  logic [MAX_COLS-1:0] c_bmp;
  logic                hit;

  assign hit = c_valid && (c_addr == addr_c) && (c_n == n_q);

  // A write during a fetch may have raced the video reads: skip the refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_valid <= 1'b0;
      c_stale <= 1'b0;
      c_addr  <= '0;
      c_n     <= '0;
      c_bmp   <= '0;
    end else begin
      if (state == IDLE && bus.req_i) c_stale <= 1'b0;
      if (state == FETCH && cnt == n_q) begin
        c_addr  <= addr_q;
        c_n     <= n_q;
        c_bmp   <= word;
        c_valid <= ~c_stale;
      end
      if (cpu_wr) begin
        c_valid <= 1'b0;
        c_stale <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      bmp    <= '0;
      code_q <= '0;
      msl_q  <= '0;
      scan_q <= '0;
      base_q <= '0;
      n_q    <= '0;
      row_q  <= '0;
      addr_q <= '0;
      cnt    <= '0;
      stage  <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_i) begin
            code_q <= bus.char_code_i;
            msl_q  <= bus.max_scanline_i;
            scan_q <= bus.scanline_i;
            base_q <= bus.font_base_i;
            n_q    <= bytes_per_row(bus.max_scanpix_i[5:0], MB);
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          row_q <= row_c;
          state <= ADR;
        end
        ADR: begin
          addr_q <= addr_c;
          cnt    <= '0;
          state  <= FETCH;
`ifdef CHAR_GLYPH_FETCH_CACHE_EN
          if (hit) begin
            bmp   <= c_bmp;
            valid <= 1'b1;
            state <= DONE;
          end
`endif
        end
        FETCH: begin
          cnt <= cnt + 4'd1;
          if (cnt != 0) stage[8*(int'(cnt)-1) +: 8] <= b_q;
          if (cnt == n_q) begin
            bmp   <= word;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // CPU reads: RAM register plus this output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_p1 <= 1'b0;
      ack   <= 1'b0;
      dat   <= '0;
    end else begin
      rd_p1 <= cpu_rd;
      ack   <= cpu_wr | rd_p1;
      if (rd_p1) dat <= a_q;
    end
  end

  assign bus.busy_o  = busy;
  assign bus.valid_o = valid;
  assign bus.bmp_o   = bmp;
  assign bus.ack_o   = ack;
  assign bus.dat_o   = dat;

endmodule

// File: tb/tb_char_glyph_fetch.sv
// Directed table-driven bench for char_glyph_fetch.
module tb_char_glyph_fetch;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  char_glyph_fetch_if bus ();

  char_glyph_fetch dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [15:0] base;
    logic [12:0] code;
    logic [5:0]  msl;
    logic [5:0]  scan;
    logic [5:0]  spx;
    int          cyc;
    logic [63:0] bmp;
  } vec_t;

  vec_t        vt [6];
  int          total = 0;
  int          passed = 0;
  int          vc;
  int          nv;
  logic [63:0] b;
  bit          bok;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic set_vid(input vec_t v);
    bus.font_base_i    = v.base;
    bus.char_code_i    = v.code;
    bus.max_scanline_i = v.msl;
    bus.scanline_i     = v.scan;
    bus.max_scanpix_i  = v.spx;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cs_i  = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = a;
    bus.dat_i = d;
    @(negedge clk);
    bus.cs_i  = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  // Called at a negedge (cycle 0); returns the valid_o cycle or -1.
  task automatic do_fetch(input vec_t v, output int cyc,
                          output logic [63:0] bm, output bit bz);
    set_vid(v);
    bus.req_i = 1'b1;
    cyc = -1;
    bm  = '0;
    bz  = 1'b1;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      @(negedge clk);
      bus.req_i = 1'b0;
      if (bus.busy_o !== 1'b1) bz = 1'b0;
      if (bus.valid_o === 1'b1) begin
        cyc = c;
        bm  = bus.bmp_o;
      end
    end
    @(negedge clk);
    if (bus.busy_o !== 1'b0) bz = 1'b0;
  endtask

  initial begin
    vt[0] = '{16'h1000, 13'h41, 6'd17, 6'd5, 6'd11, 6, 64'h0FA5};
    vt[1] = '{16'h0000, 13'h0, 6'd0, 6'd0, 6'd63, 12,
              64'h0807060504030201};
    vt[2] = '{16'h0000, 13'h0, 6'd0, 6'd0, 6'd7, 5, 64'h01};
    vt[3] = '{16'h0007, 13'h0, 6'd0, 6'd0, 6'd15, 6, 64'h0201};
    vt[4] = '{16'hFFF8, 13'h0, 6'd0, 6'd3, 6'd23, 7, 64'h040302};
    vt[5] = '{16'h2000, 13'h1, 6'd1, 6'd1, 6'd31, 8, 64'h44332211};

    rst_n     = 1'b0;
    bus.cs_i  = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.req_i = 1'b0;
    set_vid(vt[0]);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_ack", 64'(bus.ack_o), 64'd0);
    check("rst_dat", 64'(bus.dat_o), 64'd0);
    check("rst_bmp", bus.bmp_o, 64'd0);

    cpu_write(16'h192E, 8'hA5);
    cpu_write(16'h192F, 8'h0F);
    for (int i = 0; i < 8; i++) cpu_write(16'(i), 8'(i + 1));
    cpu_write(16'h200C, 8'h11);
    cpu_write(16'h200D, 8'h22);
    cpu_write(16'h200E, 8'h33);
    cpu_write(16'h200F, 8'h44);
    cpu_write(16'h0100, 8'h33);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_fetch(vt[i], vc, b, bok);
      check($sformatf("v%0d_cycle", i), 64'(vc), 64'(vt[i].cyc));
      check($sformatf("v%0d_bmp", i), b, vt[i].bmp);
      check($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
    end

    // Video read of 0x0100 collides with a CPU write in cycle 3.
    bus.font_base_i    = 16'h0100;
    bus.char_code_i    = '0;
    bus.max_scanline_i = '0;
    bus.scanline_i     = '0;
    bus.max_scanpix_i  = 6'd7;
    bus.req_i = 1'b1;
    @(negedge clk);
    bus.req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.cs_i  = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 16'h0100;
    bus.dat_i = 8'h5A;
    @(negedge clk);
    check("wr_ack", 64'(bus.ack_o), 64'd1);
    bus.cs_i = 1'b0;
    bus.we_i = 1'b0;
    @(negedge clk);
    check("coll_valid", 64'(bus.valid_o), 64'd1);
    check("coll_bmp", bus.bmp_o, 64'h33);
    @(negedge clk);
    bus.cs_i  = 1'b1;
    bus.adr_i = 16'h0100;
    @(negedge clk);
    check("rd_ack_early", 64'(bus.ack_o), 64'd0);
    bus.cs_i = 1'b0;
    @(negedge clk);
    check("rd_ack", 64'(bus.ack_o), 64'd1);
    check("rd_dat", 64'(bus.dat_o), 64'h5A);
    @(negedge clk);

    // req_i held high; CPU writes elsewhere keep any cache cold.
    set_vid(vt[2]);
    bus.req_i = 1'b1;
    bus.cs_i  = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 16'h3000;
    bus.dat_i = 8'h00;
    nv = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        check($sformatf("held_cyc%0d", nv), 64'(c), 64'(5 + nv * 6));
        check($sformatf("held_bmp%0d", nv), bus.bmp_o, 64'h01);
        nv++;
      end
      if (c == 17) begin
        bus.req_i = 1'b0;
        bus.cs_i  = 1'b0;
        bus.we_i  = 1'b0;
      end
    end
    check("held_count", 64'(nv), 64'd3);
    @(negedge clk);

    // Reset during an 8-byte fetch.
    set_vid(vt[1]);
    bus.req_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.req_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_valid", 64'(bus.valid_o), 64'd0);
    check("abort_bmp", bus.bmp_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) nv++;
    end
    check("abort_no_valid", 64'(nv), 64'd0);

    // RAM survives reset; repeat request exercises the cache.
    do_fetch(vt[0], vc, b, bok);
    check("post_rst_cycle", 64'(vc), 64'd6);
    check("post_rst_bmp", b, 64'h0FA5);
    do_fetch(vt[0], vc, b, bok);
`ifdef CHAR_GLYPH_FETCH_CACHE_EN
    check("repeat_cycle", 64'(vc), 64'd3);
`else
    check("repeat_cycle", 64'(vc), 64'd6);
`endif
    check("repeat_bmp", b, 64'h0FA5);
    cpu_write(16'h3000, 8'h00);
    do_fetch(vt[0], vc, b, bok);
    check("after_wr_cycle", 64'(vc), 64'd6);
    check("after_wr_bmp", b, 64'h0FA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
